// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file write arbiter: FSM state encodings,
// grant IDs and the collision counter width.
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_A = 2'd1,
    ISSUE_B = 2'd2
  } state_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin priority: on a tie the requester that did not win last
// time gets the grant; otherwise the single eligible requester wins.
module rr_arbiter2
  import regfile_arb_pkg::*;
(
  input  logic a_elig,
  input  logic b_elig,
  input  gnt_t last_grant,
  output logic gnt_valid,
  output gnt_t gnt
);

  always_comb begin
    gnt_valid = a_elig | b_elig;
    gnt       = GNT_A;
    if (a_elig && b_elig) begin
      gnt = (last_grant == GNT_A) ? GNT_B : GNT_A;
    end else if (b_elig) begin
      gnt = GNT_B;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with registered write port and a
// saturating collision counter. Define REGARB_ZERO_SUPPRESS_EN to suppress writes to register 0.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ack,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ack,
  output logic              wr_enable,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  collide_cnt
);

  state_t            state_reg;
  gnt_t              last_grant_reg;
  logic              a_elig;
  logic              b_elig;
  logic              gnt_valid;
  gnt_t              gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              wr_enable_next;

  // A requester whose ack is high this cycle still shows req; masking it stops a double write.
  assign a_elig = a_req & ~a_ack;
  assign b_elig = b_req & ~b_ack;

  assign a_ack = (state_reg == ISSUE_A);
  assign b_ack = (state_reg == ISSUE_B);

  rr_arbiter2 u_rr (
    .a_elig     (a_elig),
    .b_elig     (b_elig),
    .last_grant (last_grant_reg),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  always_comb begin
    sel_addr = (gnt == GNT_A) ? a_addr : b_addr;
    sel_data = (gnt == GNT_A) ? a_data : b_data;
`ifdef REGARB_ZERO_SUPPRESS_EN
    wr_enable_next = |sel_addr;
`else
    wr_enable_next = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= GNT_B;
      wr_enable      <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      collide_cnt    <= '0;
    end else begin
      if (a_elig && b_elig && (collide_cnt != '1)) begin
        collide_cnt <= collide_cnt + 1'b1;
      end
      if (gnt_valid) begin
        state_reg      <= (gnt == GNT_A) ? ISSUE_A : ISSUE_B;
        last_grant_reg <= gnt;
        wr_enable      <= wr_enable_next;
        wr_addr        <= sel_addr;
        wr_data        <= sel_data;
      end else begin
        // Address and data hold their last values while idle.
        state_reg <= IDLE;
        wr_enable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed vector table, hand
// sequences for reset and saturation, and randomized traffic against a model.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, b_req;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ack, b_ack, wr_enable;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  collide_cnt;

  int n_cmp = 0;
  int n_err = 0;
  bit zs;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .a_req       (a_req),
    .a_addr      (a_addr),
    .a_data      (a_data),
    .a_ack       (a_ack),
    .b_req       (b_req),
    .b_addr      (b_addr),
    .b_data      (b_data),
    .b_ack       (b_ack),
    .wr_enable   (wr_enable),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .collide_cnt (collide_cnt)
  );

  typedef struct {
    bit          rst;
    bit          ra;
    logic [4:0]  aa;
    logic [31:0] ad;
    bit          rb;
    logic [4:0]  ba;
    logic [31:0] bd;
    bit          e_we;
    bit          e_aack;
    bit          e_back;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit we, input bit aack, input bit back,
                           input logic [4:0] addr, input logic [31:0] data, input logic [7:0] cnt);
    check({tag, ".wr_enable"}, 64'(wr_enable), 64'(we));
    check({tag, ".a_ack"}, 64'(a_ack), 64'(aack));
    check({tag, ".b_ack"}, 64'(b_ack), 64'(back));
    check({tag, ".wr_addr"}, 64'(wr_addr), 64'(addr));
    check({tag, ".wr_data"}, 64'(wr_data), 64'(data));
    check({tag, ".collide_cnt"}, 64'(collide_cnt), 64'(cnt));
  endtask

  task automatic drive(input bit rst, input bit ra, input logic [4:0] aa, input logic [31:0] ad,
                       input bit rb, input logic [4:0] ba, input logic [31:0] bd);
    reset = rst; a_req = ra; a_addr = aa; a_data = ad;
    b_req = rb; b_addr = ba; b_data = bd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit rst, bit ra, logic [4:0] aa, logic [31:0] ad,
                              bit rb, logic [4:0] ba, logic [31:0] bd,
                              bit we, bit aack, bit back, logic [4:0] ea, logic [31:0] ed, logic [7:0] ec);
    vec_t v;
    v.rst = rst; v.ra = ra; v.aa = aa; v.ad = ad; v.rb = rb; v.ba = ba; v.bd = bd;
    v.e_we = we; v.e_aack = aack; v.e_back = back; v.e_addr = ea; v.e_data = ed; v.e_cnt = ec;
    return v;
  endfunction

  // Reference model state
  bit          m_aack, m_back, m_we, m_last_b;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_cnt;

  task automatic model_step(input bit rst, input bit ra, input logic [4:0] aa, input logic [31:0] ad,
                            input bit rb, input logic [4:0] ba, input logic [31:0] bd);
    int win;
    bit ea, eb;
    if (rst) begin
      m_aack = 0; m_back = 0; m_we = 0; m_addr = 0; m_data = 0; m_cnt = 0; m_last_b = 1;
      return;
    end
    ea = ra && !m_aack;
    eb = rb && !m_back;
    win = 0;
    if (ea && eb) begin
      if (m_cnt < 255) m_cnt = m_cnt + 1;
      win = m_last_b ? 1 : 2;
    end else if (ea) win = 1;
    else if (eb) win = 2;
    m_aack = (win == 1);
    m_back = (win == 2);
    if (win != 0) begin
      m_last_b = (win == 2);
      m_addr = (win == 1) ? aa : ba;
      m_data = (win == 1) ? ad : bd;
      m_we = !(zs && m_addr == 0);
    end else begin
      m_we = 0;
    end
  endtask

  initial begin
`ifdef REGARB_ZERO_SUPPRESS_EN
    zs = 1'b1;
`else
    zs = 1'b0;
`endif
    drive(1, 0, 0, 0, 0, 0, 0);

    // Directed table: reset/idle, single write, A/B alternation, addr 0, held-req spacing.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 14, 32'hDEADBEEF, 0, 0, 0,           1, 1, 0, 14, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 0, 14, 32'hDEADBEEF, 0, 0, 0,           0, 0, 0, 14, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 1, 3, 32'h33, 1, 7, 32'h77,             0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 32'h33, 1, 7, 32'h77,             1, 1, 0, 3, 32'h33, 1));
    vecs.push_back(mk(0, 1, 3, 32'h33, 1, 7, 32'h77,             1, 0, 1, 7, 32'h77, 1));
    vecs.push_back(mk(0, 1, 3, 32'h33, 1, 7, 32'h77,             1, 1, 0, 3, 32'h33, 1));
    vecs.push_back(mk(0, 1, 3, 32'h33, 1, 7, 32'h77,             1, 0, 1, 7, 32'h77, 1));
    vecs.push_back(mk(0, 0, 3, 32'h33, 0, 7, 32'h77,             0, 0, 0, 7, 32'h77, 1));
    vecs.push_back(mk(0, 1, 0, 32'hA5, 0, 0, 0,                  !zs, 1, 0, 0, 32'hA5, 1));
    vecs.push_back(mk(0, 0, 0, 32'hA5, 0, 0, 0,                  0, 0, 0, 0, 32'hA5, 1));
    vecs.push_back(mk(0, 1, 5, 32'h55, 0, 0, 0,                  1, 1, 0, 5, 32'h55, 1));
    vecs.push_back(mk(0, 1, 5, 32'h55, 0, 0, 0,                  0, 0, 0, 5, 32'h55, 1));
    vecs.push_back(mk(0, 1, 5, 32'h55, 0, 0, 0,                  1, 1, 0, 5, 32'h55, 1));
    vecs.push_back(mk(0, 0, 5, 32'h55, 0, 0, 0,                  0, 0, 0, 5, 32'h55, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ra, vecs[i].aa, vecs[i].ad, vecs[i].rb, vecs[i].ba, vecs[i].bd);
      tick();
      $display("vec %0d: rst=%0b a_req=%0b b_req=%0b -> we=%0b a_ack=%0b b_ack=%0b addr=%0d data=%0h cnt=%0d",
               i, vecs[i].rst, vecs[i].ra, vecs[i].rb, wr_enable, a_ack, b_ack, wr_addr, wr_data, collide_cnt);
      check_all($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_aack, vecs[i].e_back,
                vecs[i].e_addr, vecs[i].e_data, vecs[i].e_cnt);
    end

    // Reset in the cycle after a grant drops it; held b_req re-granted right after reset.
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 9, 32'h99); tick();
    $display("rst seq: grant b_ack=%0b addr=%0d", b_ack, wr_addr);
    check_all("rst_grant", 1, 0, 1, 9, 32'h99, 0);
    drive(1, 0, 0, 0, 1, 9, 32'h99); tick();
    $display("rst seq: in reset we=%0b b_ack=%0b", wr_enable, b_ack);
    check_all("rst_mid", 0, 0, 0, 0, 0, 0);
    tick();
    check_all("rst_hold", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 9, 32'h99); tick();
    $display("rst seq: after reset b_ack=%0b addr=%0d", b_ack, wr_addr);
    check_all("rst_regrant", 1, 0, 1, 9, 32'h99, 0);

    // Saturation: collisions every other cycle.
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 1, 32'h1, 1, 2, 32'h2); tick();
      if (i == 254) check("sat_255", 64'(collide_cnt), 64'd255);
      if (i == 253) check("sat_254", 64'(collide_cnt), 64'd254);
      drive(0, 0, 1, 32'h1, 0, 2, 32'h2); tick();
    end
    $display("sat seq: collide_cnt=%0d after 300 collisions", collide_cnt);
    check("sat_300", 64'(collide_cnt), 64'd255);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit rst, ra, rb;
      logic [4:0] aa, ba;
      logic [31:0] ad, bd;
      rst = (i == 0) || ($urandom_range(0, 63) == 0);
      ra = ($urandom_range(0, 9) < 7);
      rb = ($urandom_range(0, 9) < 7);
      aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      ba = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      ad = $urandom;
      bd = $urandom;
      drive(rst, ra, aa, ad, rb, ba, bd);
      model_step(rst, ra, aa, ad, rb, ba, bd);
      tick();
      if (m_aack || m_back)
        $display("rnd %0d: %s addr=%0d data=%0h we=%0b cnt=%0d", i, m_aack ? "A" : "B",
                 wr_addr, wr_data, wr_enable, collide_cnt);
      check_all($sformatf("rnd%0d", i), m_we, m_aack, m_back, m_addr, m_data, 8'(m_cnt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
